mem_stream_reader: RTL and testbench
====================================

Name: mem_stream_reader

Overview:
- Read-side engine for the asynchronous simple dual-port RAM.
- Accepts a command (base address, word count) and drives the RAM read address.
- Captures the combinational read data and emits it as a valid/ready stream, one word per cycle, with a last flag.
- Sits between a producer that fills the RAM through the write port and a downstream stream consumer.

Parameters:
- DEPTH, 6: address width in bits; the RAM holds 2**DEPTH words.
- WIDTH, 32: data word width in bits.

Ports:
- clk  in  1  single clock; the same clock as the RAM write port.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command can be accepted (high only in IDLE).
- cmd_addr  in  DEPTH  first word address.
- cmd_len  in  DEPTH+1  word count, 0..2**DEPTH.
- mem_addr  out  DEPTH  to RAM read address (addrb).
- mem_data  in  WIDTH  from RAM read data (dob); combinational, valid in the same cycle.
- out_valid  out  1  stream word valid.
- out_ready  in  1  stream consumer ready.
- out_data  out  WIDTH  stream word.
- out_last  out  1  marks the final word of the command.
- done  out  1  one-cycle pulse: command finished.
- cmd_err  out  1  one-cycle pulse: command rejected.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE.
  - ptr=0, so mem_addr=0.
  - remaining=0.
  - out_valid=0, out_data=0, out_last=0, done=0, cmd_err=0.
  - cmd_ready=1 after reset release.
- Reset mid-command: the transfer is lost and the stream is dropped without a last beat. No done pulse is produced.
- Handshakes:
  - Command transfer happens on cmd_valid & cmd_ready.
  - Stream transfer happens on out_valid & out_ready.
  - out_data and out_last are held stable while out_valid=1 and out_ready=0.
- mem_addr is driven directly from the ptr register.
- FSM states: IDLE, BUSY, DRAIN.
- IDLE (cmd_ready=1) on command accept:
  - cmd_len==0: done=1 on the next cycle, stay in IDLE.
  - Range error (see Optional Feature): cmd_err=1 on the next cycle, stay in IDLE, no reads.
  - Otherwise: ptr<=cmd_addr, remaining<=cmd_len, go to BUSY.
- BUSY:
  - load = !out_valid | out_ready.
  - On load:
    - out_data<=mem_data, out_valid<=1;
    - out_last<=(remaining==1);
    - ptr<=ptr+1, modulo 2**DEPTH;
    - remaining<=remaining-1.
  - When the load with remaining==1 occurs, go to DRAIN.
  - Without load, all registers hold.
- DRAIN:
  - When out_valid & out_ready: out_valid<=0, out_last<=0, done=1 (one cycle), go to IDLE.
- Timing and throughput:
  - Command accepted at edge T → first out_valid at edge T+2.
  - Sustains 1 word per cycle while out_ready=1.
  - Command-to-command gap is at least 2 cycles (DRAIN, then IDLE).
- Back-pressure: the pointer does not advance while out_valid=1 and out_ready=0. No word is skipped or duplicated.
- Read-during-write: a word is sampled at the load edge. A RAM write to the same address on that same edge is not seen; the old data is returned.
- Full-memory command: cmd_len=2**DEPTH reads every word exactly once. out_last is asserted on the 2**DEPTH-th word.
- cmd_err and done are never asserted in the same cycle.

Optional Feature:
- Macro: MEM_STREAM_READER_WRAP_EN.
- Defined: any cmd_addr/cmd_len combination is legal and addresses wrap modulo 2**DEPTH. cmd_err is tied to 0.
- Not defined: a command with cmd_addr+cmd_len > 2**DEPTH (computed at DEPTH+1 bits) is rejected with a cmd_err pulse and no reads.

Test Plan:
1. RAM preloaded with data=addr+0x100, DEPTH=6. Command addr=4, len=3, out_ready=1 → words 0x104, 0x105, 0x106 on consecutive cycles, first at T+2; out_last only on 0x106; done one cycle after the last handshake.
2. Same command with out_ready toggling 1,0,0,1,0,1,… → same 3 words in order, each held stable while stalled, no duplicates; mem_addr frozen during stalls.
3. cmd_len=0 → done pulse at T+1, out_valid stays 0, cmd_ready stays 1. Command addr=0, len=64 → all 64 words in order, out_last on word 63.
4. Command addr=62, len=4:
   - Without the macro → cmd_err pulse, no stream.
   - With MEM_STREAM_READER_WRAP_EN → words from addresses 62, 63, 0, 1.
5. rst_n pulled low after the 2nd word of a len=8 command, mid-cycle → out_valid, out_last, done drop immediately, mem_addr=0. After release, a new command addr=10, len=2 streams 0x10A, 0x10B correctly.
6. The write port writes 0xDEAD to addr 5 on the same edge the reader loads addr 5 → streamed word is the old value 0x105. A rerun reading addr 5 yields 0xDEAD.

Source files
------------

// File: rtl/mem_stream_reader.sv
// -----------------------------------------------------------------------------
// mem_stream_reader
//   Read-side engine for the asynchronous simple dual-port RAM. Accepts a
//   (base address, word count) command, walks the RAM read address and turns
//   the combinational read data into a valid/ready stream, one word per cycle,
//   with a last flag on the final word of the command.
//
// Parameters
//   DEPTH  address width in bits (RAM holds 2**DEPTH words)
//   WIDTH  data word width in bits
//
// Ports
//   clk        single clock, shared with the RAM write port
//   rst_n      asynchronous active-low reset
//   cmd_valid  command request
//   cmd_ready  command can be accepted (high only in IDLE)
//   cmd_addr   first word address
//   cmd_len    word count, 0..2**DEPTH
//   mem_addr   RAM read address (addrb), straight from the pointer register
//   mem_data   RAM read data (dob), combinational
//   out_valid  stream word valid
//   out_ready  stream consumer ready
//   out_data   stream word
//   out_last   final word of the command
//   done       one-cycle pulse: command finished
//   cmd_err    one-cycle pulse: command rejected
//
// Build option
//   MEM_STREAM_READER_WRAP_EN  when defined, addresses wrap modulo 2**DEPTH and
//                              every command is legal (cmd_err stays 0); when
//                              undefined, cmd_addr+cmd_len > 2**DEPTH is rejected.
// -----------------------------------------------------------------------------
module mem_stream_reader #(
   parameter int DEPTH = 6,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [DEPTH-1:0] cmd_addr,
   input  logic [DEPTH:0]   cmd_len,
   output logic [DEPTH-1:0] mem_addr,
   input  logic [WIDTH-1:0] mem_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             done,
   output logic             cmd_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [DEPTH:0] LEN_ONE = {{DEPTH{1'b0}}, 1'b1};

   state_t           state, state_nxt;
   logic [DEPTH-1:0] ptr;
   logic [DEPTH:0]   remaining;

   logic             range_bad;
   logic             cmd_zero;
   logic             cmd_reject;
   logic             cmd_start;
   logic             load;
   logic             finish;

   assign mem_addr = ptr;

`ifdef MEM_STREAM_READER_WRAP_EN
   assign range_bad = 1'b0;
`else
   // Sum at DEPTH+1 bits cannot overflow: (2**DEPTH-1) + 2**DEPTH < 2**(DEPTH+1).
   logic [DEPTH:0] cmd_end;
   assign cmd_end   = {1'b0, cmd_addr} + cmd_len;
   assign range_bad = (cmd_end > {1'b1, {DEPTH{1'b0}}});
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and datapath enables
   always_comb begin
      state_nxt  = state;
      cmd_ready  = 1'b0;
      cmd_zero   = 1'b0;
      cmd_reject = 1'b0;
      cmd_start  = 1'b0;
      load       = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               if (cmd_len == '0) begin
                  cmd_zero = 1'b1;
               end else if (range_bad) begin
                  cmd_reject = 1'b1;
               end else begin
                  cmd_start = 1'b1;
                  state_nxt = BUSY;
               end
            end
         end
         BUSY: begin
            // Output register is free when empty or being consumed this edge.
            load = !out_valid || out_ready;
            if (load && (remaining == LEN_ONE)) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (out_valid && out_ready) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: pointer, word counter, output register and status pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr       <= '0;
         remaining <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         done      <= 1'b0;
         cmd_err   <= 1'b0;
      end else begin
         done    <= cmd_zero;
         cmd_err <= cmd_reject;
         if (cmd_start) begin
            ptr       <= cmd_addr;
            remaining <= cmd_len;
         end
         if (load) begin
            out_data  <= mem_data;
            out_valid <= 1'b1;
            out_last  <= (remaining == LEN_ONE);
            ptr       <= ptr + 1'b1;
            remaining <= remaining - 1'b1;
         end
         if (finish) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_stream_reader.sv
module tb_mem_stream_reader;

   localparam int DEPTH = 6;
   localparam int WIDTH = 32;

   logic             clk;
   logic             rst_n;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [DEPTH-1:0] cmd_addr;
   logic [DEPTH:0]   cmd_len;
   logic [DEPTH-1:0] mem_addr;
   logic [WIDTH-1:0] mem_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_last;
   logic             done;
   logic             cmd_err;

   // RAM model: synchronous write, asynchronous read
   logic [WIDTH-1:0] mem [0:63];
   logic             init_done;
   logic             we;
   logic [DEPTH-1:0] wa;
   logic [WIDTH-1:0] wd;
   logic             dead_written;

   int checks;
   int errors;

   mem_stream_reader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .done      (done),
      .cmd_err   (cmd_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h100 + i;
      end else if (we) begin
         mem[wa] <= wd;
      end
   end

   assign mem_data = mem[mem_addr];

   typedef struct {
      logic             cv;
      logic [DEPTH-1:0] ca;
      logic [DEPTH:0]   cl;
      logic             rdy;
      logic             ev;
      logic [WIDTH-1:0] ed;
      logic             el;
      logic             edn;
      logic             eer;
      logic             ecr;
      logic [DEPTH-1:0] ema;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic cv, input int ca, input int cl, input logic rdy,
                               input logic ev, input int ed, input logic el, input logic edn,
                               input logic eer, input logic ecr, input int ema);
      vec_t v;
      v.cv = cv; v.ca = ca[DEPTH-1:0]; v.cl = cl[DEPTH:0]; v.rdy = rdy;
      v.ev = ev; v.ed = ed; v.el = el; v.edn = edn; v.eer = eer; v.ecr = ecr;
      v.ema = ema[DEPTH-1:0];
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_word(input logic [DEPTH-1:0] a);
      if (a == 6'd5 && dead_written) return 32'h0000DEAD;
      return 32'h100 + {26'd0, a};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue a command with out_ready held high and check every streamed word.
   task automatic collect(input string name, input int addr, input int len);
      int idx;
      bit seen_done;
      cmd_valid = 1'b1;
      cmd_addr  = addr[DEPTH-1:0];
      cmd_len   = len[DEPTH:0];
      out_ready = 1'b1;
      step();
      cmd_valid = 1'b0;
      idx = 0;
      seen_done = 0;
      for (int c = 0; c < 300; c++) begin
         if (out_valid) begin
            chk($sformatf("%s data[%0d]", name, idx), out_data,
                exp_word(6'((addr + idx) % 64)));
            chk($sformatf("%s last[%0d]", name, idx), 32'(out_last), 32'(idx == len - 1));
            idx++;
         end
         if (done) begin
            seen_done = 1;
            break;
         end
         step();
      end
      chk($sformatf("%s done seen", name), 32'(seen_done), 32'd1);
      chk($sformatf("%s word count", name), idx, len);
      step();
      chk($sformatf("%s done pulse width", name), 32'(done), 32'd0);
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      rst_n        = 1'b0;
      init_done    = 1'b0;
      dead_written = 1'b0;
      we           = 1'b0;
      wa           = '0;
      wd           = '0;
      cmd_valid    = 1'b0;
      cmd_addr     = '0;
      cmd_len      = '0;
      out_ready    = 1'b0;

      // Test 1: addr 4 len 3, ready held high
      add(1, 4, 3, 1,  0, 0,      0, 0, 0, 0, 4);
      add(0, 0, 0, 1,  1, 'h104,  0, 0, 0, 0, 5);
      add(0, 0, 0, 1,  1, 'h105,  0, 0, 0, 0, 6);
      add(0, 0, 0, 1,  1, 'h106,  1, 0, 0, 0, 7);
      add(0, 0, 0, 1,  0, 0,      0, 1, 0, 1, 7);
      add(0, 0, 0, 1,  0, 0,      0, 0, 0, 1, 7);
      // Test 2: same command, out_ready 1,0,0,1,0,1,0,1
      add(1, 4, 3, 1,  0, 0,      0, 0, 0, 0, 4);
      add(0, 0, 0, 1,  1, 'h104,  0, 0, 0, 0, 5);
      add(0, 0, 0, 0,  1, 'h104,  0, 0, 0, 0, 5);
      add(0, 0, 0, 0,  1, 'h104,  0, 0, 0, 0, 5);
      add(0, 0, 0, 1,  1, 'h105,  0, 0, 0, 0, 6);
      add(0, 0, 0, 0,  1, 'h105,  0, 0, 0, 0, 6);
      add(0, 0, 0, 1,  1, 'h106,  1, 0, 0, 0, 7);
      add(0, 0, 0, 0,  1, 'h106,  1, 0, 0, 0, 7);
      add(0, 0, 0, 1,  0, 0,      0, 1, 0, 1, 7);
      // Test 3a: zero-length command
      add(1, 9, 0, 1,  0, 0,      0, 1, 0, 1, 7);
      add(0, 0, 0, 1,  0, 0,      0, 0, 0, 1, 7);
      // Boundary: addr 63 len 1 ends exactly at the top of memory
      add(1, 63, 1, 1, 0, 0,      0, 0, 0, 0, 63);
      add(0, 0, 0, 1,  1, 'h13F,  1, 0, 0, 0, 0);
      add(0, 0, 0, 1,  0, 0,      0, 1, 0, 1, 0);
`ifdef MEM_STREAM_READER_WRAP_EN
      // Test 4: addr 62 len 4 wraps to 0
      add(1, 62, 4, 1, 0, 0,      0, 0, 0, 0, 62);
      add(0, 0, 0, 1,  1, 'h13E,  0, 0, 0, 0, 63);
      add(0, 0, 0, 1,  1, 'h13F,  0, 0, 0, 0, 0);
      add(0, 0, 0, 1,  1, 'h100,  0, 0, 0, 0, 1);
      add(0, 0, 0, 1,  1, 'h101,  1, 0, 0, 0, 2);
      add(0, 0, 0, 1,  0, 0,      0, 1, 0, 1, 2);
`else
      // Test 4: addr 62 len 4 is out of range
      add(1, 62, 4, 1, 0, 0,      0, 0, 1, 1, 0);
      add(0, 0, 0, 1,  0, 0,      0, 0, 0, 1, 0);
`endif

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst out_last",  32'(out_last),  32'd0);
      chk("rst out_data",  out_data,       32'd0);
      chk("rst done",      32'(done),      32'd0);
      chk("rst cmd_err",   32'(cmd_err),   32'd0);
      chk("rst mem_addr",  32'(mem_addr),  32'd0);
      init_done = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("rst cmd_ready", 32'(cmd_ready), 32'd1);

      // Table-driven vectors
      for (int i = 0; i < vecs.size(); i++) begin
         cmd_valid = vecs[i].cv;
         cmd_addr  = vecs[i].ca;
         cmd_len   = vecs[i].cl;
         out_ready = vecs[i].rdy;
         step();
         chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ev));
         if (vecs[i].ev) chk($sformatf("v%0d out_data", i), out_data, vecs[i].ed);
         chk($sformatf("v%0d out_last", i),  32'(out_last),  32'(vecs[i].el));
         chk($sformatf("v%0d done", i),      32'(done),      32'(vecs[i].edn));
         chk($sformatf("v%0d cmd_err", i),   32'(cmd_err),   32'(vecs[i].eer));
         chk($sformatf("v%0d cmd_ready", i), 32'(cmd_ready), 32'(vecs[i].ecr));
         chk($sformatf("v%0d mem_addr", i),  32'(mem_addr),  32'(vecs[i].ema));
      end
      cmd_valid = 1'b0;
      step();

      // Test 3b: full-memory read
      collect("full", 0, 64);

      // Test 5: reset after the second word of a len=8 command
      cmd_valid = 1'b1;
      cmd_addr  = 6'd20;
      cmd_len   = 7'd8;
      out_ready = 1'b1;
      step();
      cmd_valid = 1'b0;
      step();
      chk("rstmid word0", out_data, 32'h114);
      step();
      chk("rstmid word1", out_data, 32'h115);
      #3;
      rst_n = 1'b0;
      #1;
      chk("rstmid out_valid", 32'(out_valid), 32'd0);
      chk("rstmid out_last",  32'(out_last),  32'd0);
      chk("rstmid done",      32'(done),      32'd0);
      chk("rstmid mem_addr",  32'(mem_addr),  32'd0);
      step();
      chk("rstmid held valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("rstmid cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rstmid no done",   32'(done),      32'd0);
      collect("after_rst", 10, 2);

      // Test 6: write to addr 5 on the same edge the reader loads addr 5
      cmd_valid = 1'b1;
      cmd_addr  = 6'd5;
      cmd_len   = 7'd1;
      out_ready = 1'b1;
      step();
      cmd_valid = 1'b0;
      we = 1'b1;
      wa = 6'd5;
      wd = 32'h0000DEAD;
      step();
      we = 1'b0;
      chk("rdw valid", 32'(out_valid), 32'd1);
      chk("rdw old data", out_data, 32'h105);
      chk("rdw last", 32'(out_last), 32'd1);
      step();
      chk("rdw done", 32'(done), 32'd1);
      dead_written = 1'b1;
      step();
      collect("rdw_rerun", 5, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
